// File: rtl/smpl_sig_mc_if.sv
// Configuration and sampling-output bundle for the multi-channel sampling-signal generator.
interface smpl_sig_mc_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic [NUM_CH-1:0] en;
  logic              sync_in;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic [CNT_W-1:0]  cfg_phase;
  logic [NUM_CH-1:0] sample_sig;
  logic [NUM_CH-1:0] st;

  modport master (
    output en, sync_in, cfg_valid, cfg_ch, cfg_div, cfg_phase,
    input  cfg_ready, sample_sig, st
  );

  modport slave (
    input  en, sync_in, cfg_valid, cfg_ch, cfg_div, cfg_phase,
    output cfg_ready, sample_sig, st
  );
endinterface

// File: rtl/smpl_sig_mc.sv
// Multi-channel sampling-signal generator: per-channel divider/phase with shadowed,
// wrap-synchronous reprogramming and a global realign pulse.
module smpl_sig_mc #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 16,
  parameter int DEF_DIV = 24
) (
  input  logic          clk,
  input  logic          reset,
  smpl_sig_mc_if.slave  bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] DEF_DIV_V = CNT_W'(DEF_DIV);

  logic [NUM_CH-1:0] sel;
  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] wr;
  logic [NUM_CH-1:0] sample_vec;
  logic [NUM_CH-1:0] st_vec;
  logic              ready;

  // An out-of-range channel selects nothing, so it is always ready and writes are dropped.
  assign ready          = ~|(sel & pend);
  assign bus.cfg_ready  = ready;
  assign wr             = sel & {NUM_CH{bus.cfg_valid & ready}};
  assign bus.sample_sig = sample_vec;
  assign bus.st         = st_vec;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] div_act_reg;
    logic [CNT_W-1:0] ph_act_reg;
    logic [CNT_W-1:0] div_shd_reg;
    logic [CNT_W-1:0] ph_shd_reg;
    logic             pend_reg;
    logic             sample_reg;
    logic             st_reg;
    logic [CNT_W-1:0] div_next;
    logic [CNT_W-1:0] ph_next;
    logic [CNT_W-1:0] ph_eff;
    logic             wrap;
    logic             realign;
    logic             reload;

    assign sel[gi]        = (bus.cfg_ch == CH_W'(gi));
    assign pend[gi]       = pend_reg;
    assign sample_vec[gi] = sample_reg;
    assign st_vec[gi]     = st_reg;

    assign realign = bus.sync_in | ~bus.en[gi];
    assign wrap    = bus.en[gi] & (count_reg == div_act_reg);
    assign reload  = pend_reg & (bus.sync_in | wrap);

    // Direct writes (disabled channel) and shadow reloads never coincide: a write needs pend=0.
    always_comb begin
      div_next = div_act_reg;
      ph_next  = ph_act_reg;
      if (wr[gi] && !bus.en[gi]) begin
        div_next = bus.cfg_div;
        ph_next  = bus.cfg_phase;
      end else if (reload) begin
        div_next = div_shd_reg;
        ph_next  = ph_shd_reg;
      end
      ph_eff = (ph_next > div_next) ? div_next : ph_next;
    end

    always_ff @(posedge clk) begin
      if (wr[gi] && bus.en[gi]) begin
        div_shd_reg <= bus.cfg_div;
        ph_shd_reg  <= bus.cfg_phase;
      end
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        count_reg   <= '0;
        div_act_reg <= DEF_DIV_V;
        ph_act_reg  <= '0;
        pend_reg    <= 1'b0;
        sample_reg  <= 1'b0;
        st_reg      <= 1'b0;
      end else begin
        div_act_reg <= div_next;
        ph_act_reg  <= ph_next;

        if (reload) begin
          pend_reg <= 1'b0;
        end else if (wr[gi] && bus.en[gi]) begin
          pend_reg <= 1'b1;
        end

        if (realign) begin
          count_reg  <= ph_eff;
          sample_reg <= 1'b0;
          st_reg     <= 1'b0;
        end else if (wrap) begin
          count_reg  <= '0;
          sample_reg <= ~sample_reg;
          st_reg     <= ~sample_reg;
        end else begin
          count_reg <= count_reg + CNT_W'(1);
          st_reg    <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_smpl_sig_mc.sv
// Self-checking bench: directed scenarios plus random traffic against a countdown-to-toggle model.
module tb_smpl_sig_mc;
  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 8;
  localparam int DEF_DIV = 24;
  localparam int CH_W    = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;

  // Model: per channel, the number of enabled edges left until sample_sig toggles.
  int m_div  [NUM_CH];
  int m_ph   [NUM_CH];
  int m_sdiv [NUM_CH];
  int m_sph  [NUM_CH];
  int m_rem  [NUM_CH];
  bit m_pend [NUM_CH];
  bit m_ss   [NUM_CH];
  bit m_st   [NUM_CH];

  always #5 clk = ~clk;

  smpl_sig_mc_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .CH_W(CH_W)) ifc ();

  smpl_sig_mc #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  function automatic int eff_phase(int ph, int div);
    return (ph > div) ? div : ph;
  endfunction

  function automatic logic [NUM_CH-1:0] exp_ss();
    logic [NUM_CH-1:0] r;
    for (int i = 0; i < NUM_CH; i++) r[i] = m_ss[i];
    return r;
  endfunction

  function automatic logic [NUM_CH-1:0] exp_st();
    logic [NUM_CH-1:0] r;
    for (int i = 0; i < NUM_CH; i++) r[i] = m_st[i];
    return r;
  endfunction

  function automatic logic exp_ready();
    return !m_pend[int'(ifc.cfg_ch)];
  endfunction

  task automatic model_edge();
    bit acc;
    acc = ifc.cfg_valid && exp_ready();
    for (int i = 0; i < NUM_CH; i++) begin
      bit w;
      w = acc && (int'(ifc.cfg_ch) == i);
      if (!reset) begin
        m_div[i] = DEF_DIV; m_ph[i] = 0; m_pend[i] = 0;
        m_ss[i] = 0; m_st[i] = 0; m_rem[i] = DEF_DIV + 1;
      end else if (ifc.sync_in || !ifc.en[i]) begin
        if (w && !ifc.en[i]) begin
          m_div[i] = int'(ifc.cfg_div); m_ph[i] = int'(ifc.cfg_phase);
        end else if (m_pend[i] && ifc.sync_in) begin
          m_div[i] = m_sdiv[i]; m_ph[i] = m_sph[i]; m_pend[i] = 0;
        end
        if (w && ifc.en[i]) begin
          m_sdiv[i] = int'(ifc.cfg_div); m_sph[i] = int'(ifc.cfg_phase); m_pend[i] = 1;
        end
        m_ss[i] = 0; m_st[i] = 0;
        m_rem[i] = m_div[i] - eff_phase(m_ph[i], m_div[i]) + 1;
      end else begin
        if (m_rem[i] == 1) begin
          m_ss[i] = !m_ss[i];
          m_st[i] = m_ss[i];
          if (m_pend[i]) begin
            m_div[i] = m_sdiv[i]; m_ph[i] = m_sph[i]; m_pend[i] = 0;
          end
          m_rem[i] = m_div[i] + 1;
        end else begin
          m_rem[i]--;
          m_st[i] = 0;
        end
        if (w) begin
          m_sdiv[i] = int'(ifc.cfg_div); m_sph[i] = int'(ifc.cfg_phase); m_pend[i] = 1;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_write(int ch, int div, int ph);
    ifc.cfg_ch    = CH_W'(ch);
    ifc.cfg_div   = CNT_W'(div);
    ifc.cfg_phase = CNT_W'(ph);
    ifc.cfg_valid = 1'b1;
    $display("cfg write ch=%0d div=%0d phase=%0d", ch, div, ph);
    step();
    ifc.cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    ifc.en = '0; ifc.sync_in = 1'b0; ifc.cfg_valid = 1'b0;
    ifc.cfg_ch = '0; ifc.cfg_div = '0; ifc.cfg_phase = '0;
    reset = 1'b0;
    repeat (3) step();
    total++;
    if (ifc.sample_sig !== 4'b0000 || ifc.st !== 4'b0000) begin
      bad++;
      $display("FAIL reset_outputs sample_sig=%b st=%b want 0000/0000", ifc.sample_sig, ifc.st);
    end
    total++;
    if (ifc.cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready cfg_ready=%b want 1", ifc.cfg_ready);
    end
  endtask

  task automatic test_startup();
    int first_rise = -1;
    int st_cnt = 0;
    reset = 1'b1;
    ifc.en = '1;
    for (int k = 1; k <= 100; k++) begin
      step();
      total++;
      if (ifc.sample_sig !== exp_ss() || ifc.st !== exp_st()) begin
        bad++;
        $display("FAIL startup_outputs k=%0d sample_sig=%b st=%b want %b/%b", k, ifc.sample_sig, ifc.st, exp_ss(), exp_st());
      end
      if (ifc.st[0] === 1'b1) begin
        st_cnt++;
        if (first_rise < 0) first_rise = k;
      end
    end
    total++;
    if (first_rise != 25) begin
      bad++;
      $display("FAIL startup_first_rise got=%0d want=25", first_rise);
    end
    total++;
    if (st_cnt != 2) begin
      bad++;
      $display("FAIL startup_st_count got=%0d want=2", st_cnt);
    end
    total++;
    if (ifc.sample_sig !== 4'b0000) begin
      bad++;
      $display("FAIL startup_aligned_low sample_sig=%b want 0000", ifc.sample_sig);
    end
  endtask

  task automatic test_pending_write();
    int guard = 0;
    int t1 = -1;
    int t2 = -1;
    while (ifc.st[1] !== 1'b1 && guard < 100) begin
      step(); guard++;
    end
    total++;
    if (guard >= 100) begin
      bad++;
      $display("FAIL pend_wait_st timeout st=%b want st[1]=1", ifc.st);
    end
    repeat (5) step();
    ifc.cfg_ch = 2'd1; #1;
    total++;
    if (ifc.cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL pend_ready_before cfg_ready=%b want 1", ifc.cfg_ready);
    end
    do_write(1, 4, 0);
    total++;
    if (ifc.cfg_ready !== 1'b0) begin
      bad++;
      $display("FAIL pend_ready_after cfg_ready=%b want 0", ifc.cfg_ready);
    end
    // Second request held while pending must be ignored.
    ifc.cfg_valid = 1'b1; ifc.cfg_div = 8'd7; ifc.cfg_phase = 8'd0;
    repeat (3) begin
      step();
      total++;
      if (ifc.sample_sig !== exp_ss() || ifc.st !== exp_st() || ifc.cfg_ready !== 1'b0) begin
        bad++;
        $display("FAIL pend_hold sample_sig=%b st=%b ready=%b want %b/%b/0", ifc.sample_sig, ifc.st, ifc.cfg_ready, exp_ss(), exp_st());
      end
    end
    ifc.cfg_valid = 1'b0;
    guard = 0;
    while (ifc.cfg_ready !== 1'b1 && guard < 60) begin
      step(); guard++;
      total++;
      if (ifc.sample_sig !== exp_ss() || ifc.st !== exp_st()) begin
        bad++;
        $display("FAIL pend_wait_outputs sample_sig=%b st=%b want %b/%b", ifc.sample_sig, ifc.st, exp_ss(), exp_st());
      end
    end
    total++;
    if (guard != 16) begin
      bad++;
      $display("FAIL pend_old_half cycles_to_ready=%0d want 16", guard);
    end
    for (int k = 1; k <= 30; k++) begin
      step();
      total++;
      if (ifc.sample_sig !== exp_ss() || ifc.st !== exp_st()) begin
        bad++;
        $display("FAIL pend_new_outputs k=%0d sample_sig=%b st=%b want %b/%b", k, ifc.sample_sig, ifc.st, exp_ss(), exp_st());
      end
      if (ifc.st[1] === 1'b1) begin
        if (t1 < 0) t1 = k;
        else if (t2 < 0) t2 = k;
      end
    end
    total++;
    if (t1 != 5 || t2 - t1 != 10) begin
      bad++;
      $display("FAIL pend_new_period first=%0d period=%0d want 5 and 10", t1, t2 - t1);
    end
  endtask

  task automatic test_div0_sync();
    ifc.cfg_ch = 2'd2; #1;
    total++;
    if (ifc.cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL div0_ready cfg_ready=%b want 1", ifc.cfg_ready);
    end
    do_write(2, 0, 0);
    ifc.sync_in = 1'b1;
    step();
    ifc.sync_in = 1'b0;
    total++;
    if (ifc.sample_sig !== 4'b0000 || ifc.st !== 4'b0000) begin
      bad++;
      $display("FAIL div0_sync_clear sample_sig=%b st=%b want 0000/0000", ifc.sample_sig, ifc.st);
    end
    for (int k = 1; k <= 8; k++) begin
      step();
      total++;
      if (ifc.sample_sig[2] !== (k % 2 == 1) || ifc.st[2] !== (k % 2 == 1) ||
          ifc.sample_sig !== exp_ss() || ifc.st !== exp_st()) begin
        bad++;
        $display("FAIL div0_toggle k=%0d sample_sig=%b st=%b want %b/%b", k, ifc.sample_sig, ifc.st, exp_ss(), exp_st());
      end
    end
  endtask

  task automatic test_phase_clamp();
    int want [2] = '{7, 1};
    int ph   [2] = '{3, 20};
    for (int r = 0; r < 2; r++) begin
      int rise = -1;
      int k = 0;
      ifc.cfg_ch = 2'd3; #1;
      total++;
      if (ifc.cfg_ready !== 1'b1) begin
        bad++;
        $display("FAIL phase_ready run=%0d cfg_ready=%b want 1", r, ifc.cfg_ready);
      end
      do_write(3, 9, ph[r]);
      ifc.sync_in = 1'b1;
      step();
      ifc.sync_in = 1'b0;
      while (rise < 0 && k < 40) begin
        step(); k++;
        total++;
        if (ifc.sample_sig !== exp_ss() || ifc.st !== exp_st()) begin
          bad++;
          $display("FAIL phase_outputs run=%0d k=%0d sample_sig=%b st=%b want %b/%b", r, k, ifc.sample_sig, ifc.st, exp_ss(), exp_st());
        end
        if (ifc.sample_sig[3] === 1'b1) rise = k;
      end
      total++;
      if (rise != want[r]) begin
        bad++;
        $display("FAIL phase_first_rise phase=%0d got=%0d want=%0d", ph[r], rise, want[r]);
      end
    end
  endtask

  task automatic test_disable();
    int rise = -1;
    int k = 0;
    repeat (7) step();
    ifc.en[0] = 1'b0;
    step();
    total++;
    if (ifc.sample_sig[0] !== 1'b0 || ifc.st[0] !== 1'b0 || ifc.sample_sig !== exp_ss()) begin
      bad++;
      $display("FAIL disable_low sample_sig=%b st=%b want %b with bit0=0", ifc.sample_sig, ifc.st, exp_ss());
    end
    do_write(0, 24, 0);
    repeat (3) begin
      step();
      total++;
      if (ifc.sample_sig !== exp_ss() || ifc.st !== exp_st() || ifc.cfg_ready !== 1'b1) begin
        bad++;
        $display("FAIL disable_hold sample_sig=%b st=%b ready=%b want %b/%b/1", ifc.sample_sig, ifc.st, ifc.cfg_ready, exp_ss(), exp_st());
      end
    end
    ifc.en[0] = 1'b1;
    while (rise < 0 && k < 60) begin
      step(); k++;
      total++;
      if (ifc.sample_sig !== exp_ss() || ifc.st !== exp_st()) begin
        bad++;
        $display("FAIL reenable_outputs k=%0d sample_sig=%b st=%b want %b/%b", k, ifc.sample_sig, ifc.st, exp_ss(), exp_st());
      end
      if (ifc.sample_sig[0] === 1'b1) rise = k;
    end
    total++;
    if (rise != 25) begin
      bad++;
      $display("FAIL reenable_first_rise got=%0d want=25", rise);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      int idx;
      idx = int'($urandom_range(0, NUM_CH - 1));
      if ($urandom_range(0, 31) == 0) ifc.en[idx] = ~ifc.en[idx];
      ifc.sync_in   = ($urandom_range(0, 79) == 0);
      ifc.cfg_valid = ($urandom_range(0, 3) == 0);
      ifc.cfg_ch    = CH_W'($urandom_range(0, NUM_CH - 1));
      ifc.cfg_div   = CNT_W'($urandom_range(0, 15));
      ifc.cfg_phase = CNT_W'($urandom_range(0, 20));
      #1;
      total++;
      if (ifc.cfg_ready !== exp_ready()) begin
        bad++;
        $display("FAIL rand_ready n=%0d ch=%0d cfg_ready=%b want %b", n, ifc.cfg_ch, ifc.cfg_ready, exp_ready());
      end
      if (ifc.cfg_valid && exp_ready())
        $display("cfg write ch=%0d div=%0d phase=%0d en=%b sync=%b", ifc.cfg_ch, ifc.cfg_div, ifc.cfg_phase, ifc.en, ifc.sync_in);
      step();
      total++;
      if (ifc.sample_sig !== exp_ss() || ifc.st !== exp_st()) begin
        bad++;
        $display("FAIL rand_outputs n=%0d sample_sig=%b st=%b want %b/%b", n, ifc.sample_sig, ifc.st, exp_ss(), exp_st());
      end
    end
    ifc.cfg_valid = 1'b0;
    ifc.sync_in   = 1'b0;
    ifc.en        = '1;
  endtask

  task automatic test_reset_pending();
    int guard = 0;
    int t1 = -1;
    int t2 = -1;
    ifc.cfg_ch = 2'd1; #1;
    while (ifc.cfg_ready !== 1'b1 && guard < 300) begin
      step(); guard++;
    end
    total++;
    if (guard >= 300) begin
      bad++;
      $display("FAIL rstpend_wait_ready cfg_ready=%b want 1", ifc.cfg_ready);
    end
    do_write(1, 4, 0);
    total++;
    if (ifc.cfg_ready !== 1'b0) begin
      bad++;
      $display("FAIL rstpend_pending cfg_ready=%b want 0", ifc.cfg_ready);
    end
    step();
    reset = 1'b0;
    repeat (2) step();
    total++;
    if (ifc.sample_sig !== 4'b0000 || ifc.st !== 4'b0000 || ifc.cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL rstpend_cleared sample_sig=%b st=%b ready=%b want 0000/0000/1", ifc.sample_sig, ifc.st, ifc.cfg_ready);
    end
    reset = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      step();
      total++;
      if (ifc.sample_sig !== exp_ss() || ifc.st !== exp_st()) begin
        bad++;
        $display("FAIL rstpend_outputs k=%0d sample_sig=%b st=%b want %b/%b", k, ifc.sample_sig, ifc.st, exp_ss(), exp_st());
      end
      if (ifc.st[1] === 1'b1) begin
        if (t1 < 0) t1 = k;
        else if (t2 < 0) t2 = k;
      end
    end
    total++;
    if (t1 != 25 || t2 - t1 != 50) begin
      bad++;
      $display("FAIL rstpend_period first=%0d period=%0d want 25 and 50", t1, t2 - t1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_startup();
    test_pending_write();
    test_div0_sync();
    test_phase_clamp();
    test_disable();
    test_random();
    test_reset_pending();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/smpl_sig_mc.md
# smpl_sig_mc

Multi-channel, runtime-programmable sampling-signal generator. It replaces the fixed single-counter sampler in the FIR front end. Each of NUM_CH channels has its own divider, start phase and enable, and produces a square sampling signal plus a one-cycle start strobe. Divider and phase are reprogrammed through a valid/ready port and take effect glitch-free at the channel's next wrap, or immediately on a global sync.

## Interface
- NUM_CH, 4: number of independent channels (≥1).
- CNT_W, 16: counter, divider and phase width.
- DEF_DIV, 24: divider value loaded into every channel at reset (must fit CNT_W).
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- en  in  NUM_CH  per-channel enable, level.
- sync_in  in  1  one-cycle pulse that realigns all channels.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  config write accepted when cfg_valid & cfg_ready.
- cfg_ch  in  max(1,$clog2(NUM_CH))  target channel.
- cfg_div  in  CNT_W  new divider; half-period = cfg_div+1 cycles.
- cfg_phase  in  CNT_W  counter value loaded on realign/re-enable.
- sample_sig  out  NUM_CH  registered square sampling signal per channel.
- st  out  NUM_CH  registered one-cycle strobe, high in the cycle sample_sig[i] first reads 1.

## Operation
- Per-channel state: count, div_act, ph_act, div_shd, ph_shd, pend.
- Reset (reset=0 at an edge): count=0, div_act=DEF_DIV, ph_act=0, pend=0, sample_sig=0, st=0. Shadow contents are don't-care. Any pending config is discarded.
- Effective phase = min(ph_act, div_act), i.e. clamped at div_act.
- Channel priority per edge, highest first: reset, sync_in, en=0, terminal count, count increment.
- sync_in=1: every channel loads its shadow into div_act/ph_act if pend, then clears pend. count is set to the effective phase of the values just loaded. sample_sig=0, st=0. The same applies to disabled channels.
- en[i]=0: count=effective phase, sample_sig=0, st=0. Counting resumes on the first edge with en[i]=1.
- Terminal count (count==div_act, enabled): count=0, sample_sig toggles, st=1 iff sample_sig goes 0→1.
  - If pend, div_act/ph_act load from the shadow on this edge and pend clears. The wrap still uses count=0.
- Otherwise count increments and st=0. count never exceeds div_act.
- cfg_ready = ~pend[cfg_ch]. It is combinational and is 1 for cfg_ch ≥ NUM_CH.
- Accepted write to an enabled channel: shadow is written and pend is set.
- Accepted write to a disabled channel: div_act/ph_act are written directly and pend is unchanged (0). The next cycle's count holds the new effective phase.
- Accepted write with cfg_ch ≥ NUM_CH: no effect.
- Write coinciding with that channel's terminal count: the wrap uses the old div_act. The new value applies at the following wrap.
- Write coinciding with sync_in: the sync loads the previous shadow (if pend). The new write sets pend again.
- div_act=0: sample_sig toggles every enabled cycle, and st pulses every 2 cycles.
- Arithmetic is unsigned. Counter increment never overflows because count ≤ div_act ≤ 2^CNT_W−1.

## Timing
- Outputs are registered, with no combinational path from inputs except cfg_ready.
- sample_sig period = 2·(div_act+1) cycles at 50% duty. st is high for 1 cycle per period.
- From an enable/sync/reset-release edge with effective phase p, first rising edge of sample_sig is div_act−p+1 cycles later.
- en falling: sample_sig/st are 0 from the next edge.
- Config latency: enabled channel, ≤ one half-period (next wrap) or next sync_in. Disabled channel, 1 cycle.

## Test plan
- NUM_CH=4, CNT_W=8, DEF_DIV=24, release reset, en=4'hF → each sample_sig first rises 25 cycles later, period 50, st high 1 cycle per 50, all channels aligned.
- Mid-half-period write ch1 div=4 → cfg_ready(ch1)=0 until wrap. Old half-period of 25 completes, then period 10. A second write to ch1 during pend is not accepted.
- Write ch2 div=0, phase=0, then sync_in → sample_sig[2] toggles every cycle and st[2] pulses every 2 cycles.
- ch3 div=9, phase=3, sync_in → first rise 7 cycles after sync. Repeat with phase=20 → clamped to 9, first rise 1 cycle after sync.
- Drop en[0] mid-count → sample_sig[0]=0 next cycle. Re-enable with phase 0, div 24 → rise 25 cycles after re-enable, other channels undisturbed.
- Pending write on ch1, then assert reset mid-operation → pend cleared, div_act=24, all outputs 0. After release, ch1 period is 50.
